// File: rtl/gcd_unit_param.sv
// gcd_unit_param: subtraction-based GCD with valid/ready handshakes; optional step counter under GCD_STEP_COUNT_EN
module gcd_unit_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_err,
  output logic             busy
`ifdef GCD_STEP_COUNT_EN
  ,
  output logic [WIDTH-1:0] step_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic any_zero, finish, accept;
  // termination conditions seen by the CALC state
  always_comb begin
    any_zero = (a_r == '0) || (b_r == '0);
    finish   = any_zero || (a_r == b_r);
    accept   = in_valid && in_ready;
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next-state logic
  always_comb
    state_nx = state == IDLE ? (in_valid ? CALC : IDLE) :
               state == CALC ? (finish ? DONE : CALC) :
               (out_ready ? IDLE : DONE);
  // outputs decoded from registered state
  always_comb begin
    in_ready  = state == IDLE;
    busy      = state == CALC;
    out_valid = state == DONE;
  end
  // operand load, subtraction step and result capture
  always_ff @(posedge clk)
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      gcd_out  <= '0;
      zero_err <= 1'b0;
    end else if (accept) begin
      a_r <= a_in;
      b_r <= b_in;
    end else if (busy) begin
      if (finish) begin
        gcd_out  <= any_zero ? (a_r | b_r) : a_r;
        zero_err <= (a_r == '0) && (b_r == '0);
      end else if (a_r > b_r)
        a_r <= a_r - b_r;
      else
        b_r <= b_r - a_r;
    end
`ifdef GCD_STEP_COUNT_EN
  // saturating count of subtraction steps for the current operation
  always_ff @(posedge clk)
    if (rst || accept)
      step_cnt <= '0;
    else if (busy && !finish && step_cnt != '1)
      step_cnt <= step_cnt + 1'b1;
`endif
endmodule
